// File: rtl/ahb_master.sv
// rtl/ahb_master.sv - AHB-Lite single master with pipelined address/data slots
// Turns a valid/ready request stream into SINGLE AHB transfers, one response per request.
module ahb_master (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] haddr,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  output logic        hwrite,
  output logic [1:0]  htrans,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  input  logic [1:0]  hresp,
  input  logic        hready
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  logic        a_valid_q, a_valid_d;
  logic [31:0] a_addr_q, a_addr_d;
  logic        a_we_q, a_we_d;
  logic [1:0]  a_size_q, a_size_d;
  logic [31:0] a_wdata_q, a_wdata_d;
  logic        d_valid_q, d_valid_d;
  logic        d_we_q, d_we_d;
  logic [31:0] d_wdata_q, d_wdata_d;
  logic        hold_idle_q, hold_idle_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic adv;
  logic accept;
  logic d_done;

  always_comb begin
    adv       = hready && !hold_idle_q;
    req_ready = !a_valid_q || adv;
    accept    = req_valid && req_ready;
    // The data phase finishes whenever the slave is ready, even while A is held idle.
    d_done    = d_valid_q && hready;

    a_valid_d    = a_valid_q;
    a_addr_d     = a_addr_q;
    a_we_d       = a_we_q;
    a_size_d     = a_size_q;
    a_wdata_d    = a_wdata_q;
    d_valid_d    = d_valid_q;
    d_we_d       = d_we_q;
    d_wdata_d    = d_wdata_q;
    resp_valid_d = d_done;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    if (adv) begin
      d_valid_d = a_valid_q;
      a_valid_d = 1'b0;
      if (a_valid_q) begin
        d_we_d    = a_we_q;
        d_wdata_d = a_wdata_q;
      end
    end else if (d_done) begin
      d_valid_d = 1'b0;
    end

    if (accept) begin
      a_valid_d = 1'b1;
      a_addr_d  = req_addr;
      a_we_d    = req_we;
      a_size_d  = req_size;
      a_wdata_d = req_wdata;
    end

    // First ERROR cycle sets the hold; it lifts once the slave finishes the second cycle.
    if (hold_idle_q) hold_idle_d = !hready;
    else             hold_idle_d = d_valid_q && !hready && (hresp == HRESP_ERROR);

    if (d_done) begin
      resp_rdata_d = d_we_q ? 32'h0 : hrdata;
      resp_err_d   = (hresp == HRESP_ERROR);
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      a_valid_q    <= 1'b0;
      a_addr_q     <= 32'h0;
      a_we_q       <= 1'b0;
      a_size_q     <= 2'b00;
      a_wdata_q    <= 32'h0;
      d_valid_q    <= 1'b0;
      d_we_q       <= 1'b0;
      d_wdata_q    <= 32'h0;
      hold_idle_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      a_valid_q    <= a_valid_d;
      a_addr_q     <= a_addr_d;
      a_we_q       <= a_we_d;
      a_size_q     <= a_size_d;
      a_wdata_q    <= a_wdata_d;
      d_valid_q    <= d_valid_d;
      d_we_q       <= d_we_d;
      d_wdata_q    <= d_wdata_d;
      hold_idle_q  <= hold_idle_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign haddr      = a_addr_q;
  assign hwrite     = a_we_q;
  assign hsize      = {1'b0, a_size_q};
  assign htrans     = (a_valid_q && !hold_idle_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hburst     = 3'b000;
  assign hwdata     = d_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_ahb_master.sv
// tb/tb_ahb_master.sv - directed bench for ahb_master with reactive slave and queue model
// Expected transfers and responses come from the order of accepted requests and slave rules.
module tb_ahb_master;

  logic        hclk;
  logic        hresetn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic [1:0]  req_size;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [1:0]  hresp;
  logic        hready;

  int checks = 0;
  int errors = 0;

  ahb_master dut (
    .hclk(hclk), .hresetn(hresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .req_size(req_size),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata), .hwrite(hwrite),
    .htrans(htrans), .hsize(hsize), .hburst(hburst), .hresp(hresp), .hready(hready)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [1:0]  size;
  } xfer_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  xfer_t acc_q[$];
  xfer_t dat_q[$];
  resp_t resp_q[$];

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
  endfunction

  function automatic int wait_fn(input logic [31:0] a);
    return (a == 32'h300) ? 3 : 0;
  endfunction

  function automatic logic err_fn(input logic [31:0] a);
    return (a == 32'h100);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  // Reactive slave: zero-wait by default, 3 waits at 0x300, two-cycle ERROR at 0x100.
  logic [1:0]  smp_trans;
  logic [31:0] smp_addr;
  logic        smp_we;
  logic        smp_ready;
  logic        dp_active;
  logic [31:0] dp_addr;
  logic        dp_we;
  int          dp_waits;
  logic        dp_err;
  logic        dp_e2;

  initial begin
    hready = 1'b1; hresp = 2'b00; hrdata = 32'h0;
    dp_active = 1'b0; dp_addr = 32'h0; dp_we = 1'b0; dp_waits = 0; dp_err = 1'b0; dp_e2 = 1'b0;
    forever begin
      @(negedge hclk);
      smp_trans = htrans; smp_addr = haddr; smp_we = hwrite; smp_ready = hready;
      @(posedge hclk);
      #1;
      if (!hresetn) begin
        dp_active = 1'b0; hready = 1'b1; hresp = 2'b00;
      end else begin
        if (smp_ready) begin
          dp_active = (smp_trans == 2'b10);
          dp_addr = smp_addr; dp_we = smp_we;
          dp_waits = wait_fn(smp_addr); dp_err = err_fn(smp_addr); dp_e2 = 1'b0;
        end
        if (!dp_active) begin
          hready = 1'b1; hresp = 2'b00;
        end else if (dp_err) begin
          hrdata = 32'h0; hresp = 2'b01;
          hready = dp_e2;
          dp_e2 = 1'b1;
        end else if (dp_waits > 0) begin
          hready = 1'b0; hresp = 2'b00; hrdata = 32'hBAD0_0000;
          dp_waits--;
        end else begin
          hready = 1'b1; hresp = 2'b00;
          hrdata = dp_we ? 32'h0 : rd_fn(dp_addr);
        end
      end
    end
  end

  // Compare process: ordering of issue, data phase and responses against accepted requests.
  logic        prev_wait;
  logic [1:0]  prev_trans;
  logic [31:0] prev_addr;

  initial begin
    prev_wait = 1'b0; prev_trans = 2'b00; prev_addr = 32'h0;
  end

  always @(negedge hclk) begin
    if (!hresetn) begin
      acc_q.delete(); dat_q.delete(); resp_q.delete();
      prev_wait = 1'b0;
    end else begin
      chk("hburst", {29'h0, hburst}, 32'h0);
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_extra: got resp_valid=1 expected no response (t=%0t)", $time);
        end else begin
          resp_t r;
          r = resp_q.pop_front();
          chk("resp_err", {31'h0, resp_err}, {31'h0, r.err});
          if (!r.err) chk("resp_rdata", resp_rdata, r.rdata);
        end
      end
      if (prev_wait) begin
        chk("wait_htrans", {30'h0, htrans}, {30'h0, prev_trans});
        chk("wait_haddr", haddr, prev_addr);
      end
      if (dat_q.size() > 0) begin
        xfer_t x;
        x = dat_q[0];
        if (x.we && !err_fn(x.addr)) chk("hwdata", hwdata, x.wdata);
        if (hready) begin
          resp_t r;
          void'(dat_q.pop_front());
          r.rdata = x.we ? 32'h0 : rd_fn(x.addr);
          r.err = err_fn(x.addr);
          resp_q.push_back(r);
        end
      end
      if (htrans == 2'b10 && hready) begin
        if (acc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL issue_extra: got NONSEQ at %h expected no transfer (t=%0t)", haddr, $time);
        end else begin
          xfer_t x;
          x = acc_q.pop_front();
          chk("issue_haddr", haddr, x.addr);
          chk("issue_hwrite", {31'h0, hwrite}, {31'h0, x.we});
          chk("issue_hsize", {29'h0, hsize}, {30'h0, x.size});
          dat_q.push_back(x);
        end
      end
      if (req_valid && req_ready) begin
        xfer_t x;
        x.addr = req_addr; x.we = req_we; x.wdata = req_wdata; x.size = req_size;
        acc_q.push_back(x);
      end
      prev_wait  = !hready && (hresp == 2'b00) && (htrans == 2'b10);
      prev_trans = htrans;
      prev_addr  = haddr;
    end
  end

  task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [1:0] sz);
    req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd; req_size = sz;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    hresetn = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_we = 1'b0; req_size = 2'b00;
    #2;
    chk("rst_htrans", {30'h0, htrans}, 32'h0);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_hwrite", {31'h0, hwrite}, 32'h0);
    chk("rst_hsize", {29'h0, hsize}, 32'h0);
    chk("rst_hwdata", hwdata, 32'h0);
    chk("rst_hburst", {29'h0, hburst}, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    @(posedge hclk);
    #3;
    hresetn = 1'b1;

    // Single read: NONSEQ at N+1, response at N+3
    step(); drive(32'h10, 1'b0, 32'h0, 2'd2);
    @(negedge hclk); chk("t1_ready", {31'h0, req_ready}, 32'h1);
    step(); req_valid = 1'b0;
    @(negedge hclk);
    chk("t1_htrans", {30'h0, htrans}, 32'h2);
    chk("t1_haddr", haddr, 32'h10);
    chk("t1_hsize", {29'h0, hsize}, 32'h2);
    chk("t1_rv_n1", {31'h0, resp_valid}, 32'h0);
    step(); @(negedge hclk); chk("t1_rv_n2", {31'h0, resp_valid}, 32'h0);
    step(); @(negedge hclk);
    chk("t1_rv_n3", {31'h0, resp_valid}, 32'h1);
    chk("t1_rdata", resp_rdata, 32'hDEADBEEF);
    chk("t1_err", {31'h0, resp_err}, 32'h0);
    idle(3);

    // Back-to-back write then read
    drive(32'h20, 1'b1, 32'h12345678, 2'd2);
    step(); drive(32'h24, 1'b0, 32'h0, 2'd2);
    @(negedge hclk); chk("t2_ready", {31'h0, req_ready}, 32'h1);
    step(); req_valid = 1'b0;
    @(negedge hclk);
    chk("t2_haddr", haddr, 32'h24);
    chk("t2_htrans", {30'h0, htrans}, 32'h2);
    chk("t2_hwdata", hwdata, 32'h12345678);
    step(); @(negedge hclk);
    chk("t2_rv_w", {31'h0, resp_valid}, 32'h1);
    chk("t2_rdata_w", resp_rdata, 32'h0);
    step(); @(negedge hclk);
    chk("t2_rv_r", {31'h0, resp_valid}, 32'h1);
    chk("t2_rdata_r", resp_rdata, 32'hA5A50024);
    idle(3);

    // Wait states: 3-cycle stall in write data phase, two requests behind it
    drive(32'h300, 1'b1, 32'hCAFE0001, 2'd2);
    step(); drive(32'h304, 1'b0, 32'h0, 2'd2);
    step(); drive(32'h308, 1'b0, 32'h0, 2'd2);
    for (int k = 0; k < 3; k++) begin
      @(negedge hclk);
      chk("t3_ready", {31'h0, req_ready}, 32'h0);
      chk("t3_haddr", haddr, 32'h304);
      chk("t3_htrans", {30'h0, htrans}, 32'h2);
      chk("t3_hwdata", hwdata, 32'hCAFE0001);
      chk("t3_rv", {31'h0, resp_valid}, 32'h0);
      step();
    end
    @(negedge hclk); chk("t3_ready_end", {31'h0, req_ready}, 32'h1);
    step(); req_valid = 1'b0;
    @(negedge hclk);
    chk("t3_rv_w", {31'h0, resp_valid}, 32'h1);
    chk("t3_err_w", {31'h0, resp_err}, 32'h0);
    idle(5);

    // Two-cycle ERROR with a read waiting in the address phase
    drive(32'h100, 1'b0, 32'h0, 2'd2);
    step(); drive(32'h104, 1'b0, 32'h0, 2'd2);
    step(); req_valid = 1'b0;
    @(negedge hclk);
    chk("t4_e1_htrans", {30'h0, htrans}, 32'h2);
    chk("t4_e1_ready", {31'h0, req_ready}, 32'h0);
    step(); @(negedge hclk);
    chk("t4_e2_htrans", {30'h0, htrans}, 32'h0);
    chk("t4_e2_haddr", haddr, 32'h104);
    chk("t4_e2_ready", {31'h0, req_ready}, 32'h0);
    step(); @(negedge hclk);
    chk("t4_e3_rv", {31'h0, resp_valid}, 32'h1);
    chk("t4_e3_err", {31'h0, resp_err}, 32'h1);
    chk("t4_e3_htrans", {30'h0, htrans}, 32'h2);
    chk("t4_e3_haddr", haddr, 32'h104);
    step(); step(); @(negedge hclk);
    chk("t4_rv2", {31'h0, resp_valid}, 32'h1);
    chk("t4_err2", {31'h0, resp_err}, 32'h0);
    chk("t4_rdata2", resp_rdata, 32'hA5A50104);
    idle(3);

    // Reset during a data phase
    drive(32'h40, 1'b0, 32'h0, 2'd2);
    step(); drive(32'h44, 1'b0, 32'h0, 2'd2);
    step(); req_valid = 1'b0;
    #1; hresetn = 1'b0;
    #1;
    chk("t5_htrans", {30'h0, htrans}, 32'h0);
    chk("t5_rv", {31'h0, resp_valid}, 32'h0);
    chk("t5_ready", {31'h0, req_ready}, 32'h1);
    @(posedge hclk); #3; hresetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge hclk);
      chk("t5_no_resp", {31'h0, resp_valid}, 32'h0);
      chk("t5_ready_after", {31'h0, req_ready}, 32'h1);
      step();
    end

    // Byte and halfword sizes
    drive(32'h50, 1'b0, 32'h0, 2'd0);
    step(); drive(32'h52, 1'b1, 32'h0000BEEF, 2'd1);
    @(negedge hclk); chk("t6_hsize_b", {29'h0, hsize}, 32'h0);
    step(); req_valid = 1'b0;
    @(negedge hclk); chk("t6_hsize_h", {29'h0, hsize}, 32'h1);
    idle(4);

    // Sustained throughput: six back-to-back reads, one response per cycle
    for (int i = 0; i < 6; i++) begin
      drive(32'h200 + 32'(4 * i), 1'b0, 32'h0, 2'd2);
      @(negedge hclk);
      chk("t7_ready", {31'h0, req_ready}, 32'h1);
      if (i >= 3) chk("t7_rv", {31'h0, resp_valid}, 32'h1);
      step();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge hclk);
      chk("t7_rv_tail", {31'h0, resp_valid}, (i < 3) ? 32'h1 : 32'h0);
      step();
    end

    for (int i = 0; i < 20 && (acc_q.size() + dat_q.size() + resp_q.size()) != 0; i++) step();
    chk("drain", 32'(acc_q.size() + dat_q.size() + resp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
